// File: rtl/comb_bist_ctrl_if.sv
// Signal bundle between the BIST controller, the host that starts it and the
// combinational (or registered) netlist being exercised.
`timescale 1ns/1ps
interface comb_bist_ctrl_if #(
   parameter int IN_W   = 13,
   parameter int OUT_W  = 5,
   parameter int MISR_W = 16,
   parameter int N_PAT  = 256
);
   localparam int CNT_W = $clog2(N_PAT + 1);

   logic              start;
   logic              abort;
   logic [MISR_W-1:0] golden_sig;
   logic [IN_W-1:0]   dut_in;
   logic [OUT_W-1:0]  dut_out;
   logic              busy;
   logic              done;
   logic              pass;
   logic [MISR_W-1:0] signature;
   logic [CNT_W-1:0]  pat_cnt;

   // Environment side: host controls plus the netlist response.
   modport master (
      output start, abort, golden_sig, dut_out,
      input  dut_in, busy, done, pass, signature, pat_cnt
   );

   // Controller side.
   modport slave (
      input  start, abort, golden_sig, dut_out,
      output dut_in, busy, done, pass, signature, pat_cnt
   );
endinterface

// File: rtl/comb_bist_ctrl.sv
// BIST controller: drives a netlist from a Galois LFSR, one pattern per clock,
// folds the responses into a MISR and compares the signature with a golden one.
// PIPE_LAT delays the capture window to match a registered netlist.
`timescale 1ns/1ps
module comb_bist_ctrl #(
   parameter int                IN_W      = 13,
   parameter int                OUT_W     = 5,
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] LFSR_POLY = 16'hB400,
   parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
   parameter int                MISR_W    = 16,
   parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
   parameter int                N_PAT     = 256,
   parameter int                PIPE_LAT  = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   comb_bist_ctrl_if.slave bus
);

   localparam int               CNT_W    = $clog2(N_PAT + 1);
   localparam logic [CNT_W-1:0] LAST_PAT = CNT_W'(N_PAT - 1);
   localparam int               DRN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [MISR_W-1:0] misr_q, misr_d;
   logic [CNT_W-1:0]  pat_cnt_q, pat_cnt_d;
   logic [DRN_W-1:0]  drn_cnt_q, drn_cnt_d;
   logic              load;
   logic              run;
   logic              cap_vld;

   // Galois step, right-shift form: the bit falling out folds the polynomial back in.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
   endfunction

   // MISR step, left-shift form, with the response zero-extended into the low bits.
   function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                   input logic [OUT_W-1:0]  r);
      return {m[MISR_W-2:0], 1'b0} ^ (m[MISR_W-1] ? MISR_POLY : '0) ^ MISR_W'(r);
   endfunction

   assign run = (state_q == S_RUN);

   // Next-state logic: sequencing, pattern generation and run bookkeeping.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      pat_cnt_d = pat_cnt_q;
      drn_cnt_d = drn_cnt_q;
      load      = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d = S_RUN;
               load    = 1'b1;
            end
         end
         S_RUN: begin
            lfsr_d    = lfsr_step(lfsr_q);
            pat_cnt_d = pat_cnt_q + 1'b1;
            if (pat_cnt_q == LAST_PAT) begin
               drn_cnt_d = '0;
               state_d   = (PIPE_LAT == 0) ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            drn_cnt_d = drn_cnt_q + 1'b1;
            if (drn_cnt_q == LAST_DRN) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         lfsr_d    = SEED;
         pat_cnt_d = '0;
      end

      // Abort wins over start and every other transition; the LFSR just holds.
      if (bus.abort) begin
         state_d   = S_IDLE;
         lfsr_d    = lfsr_q;
         pat_cnt_d = '0;
         drn_cnt_d = '0;
         load      = 1'b0;
      end

      // An all-zero LFSR would lock up, so it is forced back to the seed.
      if (lfsr_q == '0) begin
         lfsr_d = SEED;
      end
   end

   // Signature update: cleared on a new run, otherwise one fold per valid capture.
   always_comb begin
      misr_d = misr_q;
      if (load) begin
         misr_d = '0;
      end else if (cap_vld && !bus.abort) begin
         misr_d = misr_step(misr_q, bus.dut_out);
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      if (!rst_n) begin
         state_q   <= S_IDLE;
         lfsr_q    <= SEED;
         misr_q    <= '0;
         pat_cnt_q <= '0;
         drn_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         misr_q    <= misr_d;
         pat_cnt_q <= pat_cnt_d;
         drn_cnt_q <= drn_cnt_d;
      end
   end

   // Capture window: RUN delayed by the netlist latency, so capture k sees pattern k.
   generate
      if (PIPE_LAT == 0) begin : g_no_pipe
         assign cap_vld = run;
      end else begin : g_pipe
         logic [PIPE_LAT-1:0] cap_pipe_q;

         // Valid shift register, flushed by abort.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cap_pipe_q <= '0;
            end else if (bus.abort) begin
               cap_pipe_q <= '0;
            end else begin
               cap_pipe_q[0] <= run;
               for (int i = 1; i < PIPE_LAT; i++) begin
                  cap_pipe_q[i] <= cap_pipe_q[i-1];
               end
            end
         end

         assign cap_vld = cap_pipe_q[PIPE_LAT-1];
      end
   endgenerate

   assign bus.dut_in    = lfsr_q[IN_W-1:0];
   assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign bus.done      = (state_q == S_DONE);
   assign bus.pass      = (state_q == S_DONE) && (misr_q == bus.golden_sig);
   assign bus.signature = misr_q;
   assign bus.pat_cnt   = pat_cnt_q;

endmodule

// File: tb/tb_comb_bist_ctrl.sv
// Bench for comb_bist_ctrl: three controllers (256 patterns/no latency,
// 4 patterns/latency 2, 3 patterns/no latency) against a pattern-by-pattern
// signature model driven by randomly keyed response functions.
`timescale 1ns/1ps
module tb_comb_bist_ctrl;

   localparam logic [15:0] SEED  = 16'hACE1;
   localparam logic [15:0] LPOLY = 16'hB400;
   localparam logic [15:0] MPOLY = 16'h1021;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          errors = 0;

   logic [31:0] key0  = 32'd0;
   logic [31:0] key1  = 32'd0;
   int          mode1 = 0;
   logic [4:0]  cval1 = 5'd0;
   logic [4:0]  d1_q  = 5'd0;
   logic [4:0]  d2_q  = 5'd0;

   logic [15:0] t2_lit [4] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};

   always #5 clk = ~clk;

   comb_bist_ctrl_if #(.IN_W(13), .OUT_W(5), .MISR_W(16), .N_PAT(256)) bif0 ();
   comb_bist_ctrl_if #(.IN_W(13), .OUT_W(5), .MISR_W(16), .N_PAT(4))   bif1 ();
   comb_bist_ctrl_if #(.IN_W(13), .OUT_W(5), .MISR_W(16), .N_PAT(3))   bif2 ();

   comb_bist_ctrl #(.IN_W(13), .OUT_W(5), .N_PAT(256), .PIPE_LAT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bif0));
   comb_bist_ctrl #(.IN_W(13), .OUT_W(5), .N_PAT(4), .PIPE_LAT(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bif1));
   comb_bist_ctrl #(.IN_W(13), .OUT_W(5), .N_PAT(3), .PIPE_LAT(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bif2));

   // ---------------- reference model ----------------
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic [15:0] h;
      h = s / 16'd2;
      if (s % 16'd2 == 16'd1) h = h ^ LPOLY;
      return h;
   endfunction

   function automatic logic [15:0] misr_next(input logic [15:0] m, input logic [4:0] r);
      logic [16:0] t;
      logic [15:0] v;
      t = {1'b0, m} * 17'd2;
      v = t[15:0];
      if (t[16]) v = v ^ MPOLY;
      return v ^ {11'd0, r};
   endfunction

   // Stand-in for a generated netlist: a keyed mixing function or a constant.
   function automatic logic [4:0] resp(input logic [12:0] x, input logic [31:0] key,
                                       input int mode, input logic [4:0] cval);
      logic [31:0] t;
      if (mode == 0) return cval;
      t = ({19'd0, x} * {16'd0, key[15:0]}) ^ ({19'd0, x} >> key[19:16]) ^ {20'd0, key[31:20]};
      return t[4:0] ^ t[12:8];
   endfunction

   function automatic logic [15:0] ref_sig(input int n, input logic [31:0] key,
                                           input int mode, input logic [4:0] cval);
      logic [15:0] s;
      logic [15:0] m;
      s = SEED;
      m = 16'd0;
      for (int k = 0; k < n; k++) begin
         m = misr_next(m, resp(s[12:0], key, mode, cval));
         s = lfsr_next(s);
         if (s == 16'd0) s = SEED;
      end
      return m;
   endfunction

   // ---------------- netlist stand-ins ----------------
   assign bif0.dut_out = resp(bif0.dut_in, key0, 1, 5'd0);
   assign bif2.dut_out = 5'h01;

   // Two-stage registered netlist for the PIPE_LAT=2 controller.
   always @(posedge clk) begin
      d1_q <= resp(bif1.dut_in, key1, mode1, cval1);
      d2_q <= d1_q;
   end
   assign bif1.dut_out = d2_q;

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic done_of(input int which);
      case (which)
         0:       return bif0.done;
         1:       return bif1.done;
         default: return bif2.done;
      endcase
   endfunction

   task automatic wait_done(input int which, input int budget, output int cyc);
      cyc = 0;
      while (done_of(which) !== 1'b1 && cyc < budget) begin
         tick();
         cyc++;
      end
      checks++;
      if (done_of(which) !== 1'b1) begin
         errors++;
         $display("FAIL wait_done dut%0d: done=%b after %0d clocks, required 1", which, done_of(which), budget);
      end
   endtask

   function automatic logic [40:0] snap0();
      return {bif0.busy, bif0.done, bif0.pass, bif0.pat_cnt, bif0.signature, bif0.dut_in};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) tick();
      checks++;
      if (snap0() !== {3'b000, 9'd0, 16'h0000, 13'h0CE1}) begin
         errors++;
         $display("FAIL reset_hold: got %h, required %h", snap0(), {3'b000, 9'd0, 16'h0000, 13'h0CE1});
      end
      rst_n = 1'b1;
      tick();
      bif0.start = 1'b1;
      tick();
      bif0.start = 1'b0;
      repeat (5) tick();
      checks++;
      if (bif0.busy !== 1'b1 || bif0.pat_cnt !== 9'd5) begin
         errors++;
         $display("FAIL reset_prerun: busy=%b pat_cnt=%0d, required busy=1 pat_cnt=5", bif0.busy, bif0.pat_cnt);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (snap0() !== {3'b000, 9'd0, 16'h0000, 13'h0CE1}) begin
         errors++;
         $display("FAIL reset_midrun: got %h, required %h", snap0(), {3'b000, 9'd0, 16'h0000, 13'h0CE1});
      end
      repeat (3) tick();
      checks++;
      if (bif0.done !== 1'b0 || bif0.busy !== 1'b0 || bif1.done !== 1'b0 || bif2.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_done: done0=%b busy0=%b done1=%b done2=%b, required all 0",
                  bif0.done, bif0.busy, bif1.done, bif2.done);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_lfsr_seq();
      logic [15:0] s;
      logic [15:0] exp_sig;
      int          cyc;
      int          bad;
      key0 = $urandom();
      s    = SEED;
      bad  = 0;
      bif0.start = 1'b1;
      tick();
      bif0.start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (k <= 4) begin
            checks++;
            if (bif0.dut_in !== t2_lit[k-1][12:0]) begin
               errors++;
               $display("FAIL lfsr_lit cycle %0d: dut_in=%h, required %h", k, bif0.dut_in, t2_lit[k-1][12:0]);
            end
         end
         if (bif0.dut_in !== s[12:0] || bif0.pat_cnt !== 9'(k - 1) || bif0.busy !== 1'b1) begin
            bad++;
            $display("FAIL lfsr_seq cycle %0d: dut_in=%h pat_cnt=%0d busy=%b, required %h %0d 1",
                     k, bif0.dut_in, bif0.pat_cnt, bif0.busy, s[12:0], k - 1);
         end
         tick();
         s = lfsr_next(s);
      end
      checks++;
      if (bad != 0) errors++;
      wait_done(0, 300, cyc);
      checks++;
      if (40 + cyc != 256) begin
         errors++;
         $display("FAIL run_length256: done after %0d clocks, required 256", 40 + cyc);
      end
      exp_sig = ref_sig(256, key0, 1, 5'd0);
      checks++;
      if (bif0.signature !== exp_sig || bif0.pat_cnt !== 9'd256) begin
         errors++;
         $display("FAIL sig256: signature=%h pat_cnt=%0d, required %h 256", bif0.signature, bif0.pat_cnt, exp_sig);
      end
      bif0.golden_sig = exp_sig;
      #1;
      checks++;
      if (bif0.pass !== 1'b1) begin
         errors++;
         $display("FAIL pass256_match: pass=%b, required 1", bif0.pass);
      end
      bif0.golden_sig = exp_sig ^ 16'h8000;
      #1;
      checks++;
      if (bif0.pass !== 1'b0) begin
         errors++;
         $display("FAIL pass256_mismatch: pass=%b, required 0", bif0.pass);
      end
   endtask

   task automatic test_length();
      int          bad;
      int          cyc;
      logic [15:0] exp_sig;
      mode1 = 0;
      cval1 = 5'd0;
      bif1.golden_sig = 16'h0000;
      bad = 0;
      bif1.start = 1'b1;
      tick();
      bif1.start = 1'b0;
      // Start sampled in cycle 0; done must first show in cycle 7.
      for (int c = 1; c <= 6; c++) begin
         if (bif1.done !== 1'b0 || bif1.busy !== 1'b1) begin
            bad++;
            $display("FAIL length_early cycle %0d: done=%b busy=%b, required 0 1", c, bif1.done, bif1.busy);
         end
         tick();
      end
      checks++;
      if (bad != 0) errors++;
      checks++;
      if (bif1.done !== 1'b1 || bif1.busy !== 1'b0 || bif1.pat_cnt !== 3'd4) begin
         errors++;
         $display("FAIL length_done: done=%b busy=%b pat_cnt=%0d, required 1 0 4", bif1.done, bif1.busy, bif1.pat_cnt);
      end
      checks++;
      if (bif1.signature !== 16'h0000 || bif1.pass !== 1'b1) begin
         errors++;
         $display("FAIL length_sig0: signature=%h pass=%b, required 0000 1", bif1.signature, bif1.pass);
      end
      bif1.golden_sig = 16'h0001;
      #1;
      checks++;
      if (bif1.pass !== 1'b0) begin
         errors++;
         $display("FAIL length_golden1: pass=%b, required 0", bif1.pass);
      end
      // Random netlists through the latency-2 path, each restarted from DONE.
      for (int r = 0; r < 4; r++) begin
         key1    = $urandom();
         mode1   = 1;
         exp_sig = ref_sig(4, key1, 1, 5'd0);
         bif1.golden_sig = exp_sig;
         bif1.start = 1'b1;
         tick();
         bif1.start = 1'b0;
         checks++;
         if (bif1.done !== 1'b0 || bif1.busy !== 1'b1) begin
            errors++;
            $display("FAIL pipe_restart %0d: done=%b busy=%b, required 0 1", r, bif1.done, bif1.busy);
         end
         wait_done(1, 20, cyc);
         checks++;
         if (cyc != 6 || bif1.signature !== exp_sig || bif1.pass !== 1'b1) begin
            errors++;
            $display("FAIL pipe_sig %0d: clocks=%0d signature=%h pass=%b, required 6 %h 1",
                     r, cyc, bif1.signature, bif1.pass, exp_sig);
         end
      end
   endtask

   task automatic test_compaction();
      int cyc;
      bif2.golden_sig = 16'h0007;
      bif2.start = 1'b1;
      tick();
      bif2.start = 1'b0;
      wait_done(2, 10, cyc);
      checks++;
      if (cyc != 3 || bif2.signature !== 16'h0007 || bif2.pat_cnt !== 2'd3 || bif2.pass !== 1'b1) begin
         errors++;
         $display("FAIL compact3: clocks=%0d signature=%h pat_cnt=%0d pass=%b, required 3 0007 3 1",
                  cyc, bif2.signature, bif2.pat_cnt, bif2.pass);
      end
   endtask

   task automatic test_abort();
      int          cyc;
      logic [15:0] sig_before;
      logic [15:0] exp_sig;
      key0 = $urandom();
      bif0.start = 1'b1;
      tick();
      bif0.start = 1'b0;
      cyc = 0;
      while (bif0.pat_cnt !== 9'd10 && cyc < 50) begin
         tick();
         cyc++;
      end
      checks++;
      if (bif0.pat_cnt !== 9'd10) begin
         errors++;
         $display("FAIL abort_reach10: pat_cnt=%0d, required 10", bif0.pat_cnt);
      end
      sig_before = bif0.signature;
      bif0.abort = 1'b1;
      tick();
      bif0.abort = 1'b0;
      checks++;
      if (bif0.busy !== 1'b0 || bif0.done !== 1'b0 || bif0.pat_cnt !== 9'd0 || bif0.signature !== sig_before) begin
         errors++;
         $display("FAIL abort_idle: busy=%b done=%b pat_cnt=%0d signature=%h, required 0 0 0 %h",
                  bif0.busy, bif0.done, bif0.pat_cnt, bif0.signature, sig_before);
      end
      repeat (2) tick();
      checks++;
      if (bif0.busy !== 1'b0 || bif0.pat_cnt !== 9'd0) begin
         errors++;
         $display("FAIL abort_stays: busy=%b pat_cnt=%0d, required 0 0", bif0.busy, bif0.pat_cnt);
      end
      bif0.start = 1'b1;
      tick();
      bif0.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (bif0.dut_in !== t2_lit[k][12:0] || bif0.pat_cnt !== 9'(k)) begin
            errors++;
            $display("FAIL abort_rerun cycle %0d: dut_in=%h pat_cnt=%0d, required %h %0d",
                     k + 1, bif0.dut_in, bif0.pat_cnt, t2_lit[k][12:0], k);
         end
         tick();
      end
      wait_done(0, 300, cyc);
      exp_sig = ref_sig(256, key0, 1, 5'd0);
      checks++;
      if (bif0.signature !== exp_sig) begin
         errors++;
         $display("FAIL abort_rerun_sig: signature=%h, required %h", bif0.signature, exp_sig);
      end
      // abort beats a simultaneous start in DONE
      bif0.start = 1'b1;
      bif0.abort = 1'b1;
      tick();
      bif0.start = 1'b0;
      bif0.abort = 1'b0;
      checks++;
      if (bif0.busy !== 1'b0 || bif0.done !== 1'b0 || bif0.pass !== 1'b0) begin
         errors++;
         $display("FAIL abort_priority: busy=%b done=%b pass=%b, required 0 0 0", bif0.busy, bif0.done, bif0.pass);
      end
   endtask

   task automatic test_restart();
      int          cyc;
      logic [15:0] exp_sig;
      logic [15:0] sig1;
      key0    = $urandom();
      exp_sig = ref_sig(256, key0, 1, 5'd0);
      bif0.golden_sig = exp_sig;
      bif0.start = 1'b1;
      tick();
      bif0.start = 1'b0;
      repeat (20) tick();
      bif0.start = 1'b1;
      tick();
      bif0.start = 1'b0;
      checks++;
      if (bif0.pat_cnt !== 9'd21 || bif0.busy !== 1'b1) begin
         errors++;
         $display("FAIL restart_ignored: pat_cnt=%0d busy=%b, required 21 1", bif0.pat_cnt, bif0.busy);
      end
      wait_done(0, 300, cyc);
      checks++;
      if (21 + cyc != 256 || bif0.signature !== exp_sig || bif0.pass !== 1'b1) begin
         errors++;
         $display("FAIL restart_run1: clocks=%0d signature=%h pass=%b, required 256 %h 1",
                  21 + cyc, bif0.signature, bif0.pass, exp_sig);
      end
      sig1 = bif0.signature;
      bif0.start = 1'b1;
      tick();
      bif0.start = 1'b0;
      checks++;
      if (bif0.done !== 1'b0 || bif0.busy !== 1'b1 || bif0.pat_cnt !== 9'd0 || bif0.dut_in !== 13'h0CE1) begin
         errors++;
         $display("FAIL restart_from_done: done=%b busy=%b pat_cnt=%0d dut_in=%h, required 0 1 0 0ce1",
                  bif0.done, bif0.busy, bif0.pat_cnt, bif0.dut_in);
      end
      wait_done(0, 300, cyc);
      checks++;
      if (bif0.signature !== sig1 || bif0.signature !== exp_sig) begin
         errors++;
         $display("FAIL restart_run2: signature=%h, required %h", bif0.signature, exp_sig);
      end
   endtask

   initial begin
      bif0.start = 1'b0; bif0.abort = 1'b0; bif0.golden_sig = 16'h0000;
      bif1.start = 1'b0; bif1.abort = 1'b0; bif1.golden_sig = 16'h0000;
      bif2.start = 1'b0; bif2.abort = 1'b0; bif2.golden_sig = 16'h0000;
      test_reset();
      test_lfsr_seq();
      test_length();
      test_compaction();
      test_abort();
      test_restart();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog");
   end

endmodule
